// File: rtl/bank_addr_xbar_pipe.sv
// Bank address crossbar with a single registered output stage.
// Each output lane picks one source lane; duplicate selects are flagged as a
// conflict, and in permutation mode a conflicting transfer is dropped and
// recorded in a sticky error bit.
module bank_addr_xbar_pipe #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LANES*ADDR_W-1:0]   in_addr,
    input  logic [LANES*$clog2(LANES)-1:0] in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      perm_mode,
    output logic [LANES*ADDR_W-1:0]   out_addr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_conflict,
    output logic                      err_sticky,
    input  logic                      err_clr,
    output logic [CNT_W-1:0]          xfer_cnt
);

    localparam int unsigned SEL_W = $clog2(LANES);

    logic [ADDR_W-1:0]       w_src [LANES];
    logic [SEL_W-1:0]        w_sel [LANES];
    logic [LANES*ADDR_W-1:0] w_routed;
    logic                    w_conflict;
    logic                    w_accept;
    logic                    w_drop;
    logic                    w_fire;

    logic [LANES*ADDR_W-1:0] r_out_addr;
    logic                    r_out_valid;
    logic                    r_out_conflict;
    logic                    r_err_sticky;
    logic [CNT_W-1:0]        r_xfer_cnt;

    // Unpack the flat lane buses into per-lane arrays.
    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            w_src[k] = in_addr[k*ADDR_W +: ADDR_W];
            w_sel[k] = in_sel[k*SEL_W +: SEL_W];
        end
    end

    // Crossbar: output lane j takes the source lane named by its select.
    always_comb begin
        w_routed = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            w_routed[j*ADDR_W +: ADDR_W] = w_src[w_sel[j]];
        end
    end

    // Conflict when any two output lanes name the same source.
    always_comb begin
        w_conflict = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            for (int unsigned j = i + 1; j < LANES; j++) begin
                if (w_sel[i] == w_sel[j]) begin
                    w_conflict = 1'b1;
                end
            end
        end
    end

    // A full stage can refill in the same cycle it drains.
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_drop   = w_accept && perm_mode && w_conflict;
    assign w_fire   = r_out_valid && out_ready;

    // Output pipeline register; dropped transfers leave the data untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_addr     <= '0;
            r_out_valid    <= 1'b0;
            r_out_conflict <= 1'b0;
        end else if (w_accept) begin
            if (w_drop) begin
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid    <= 1'b1;
                r_out_addr     <= w_routed;
                r_out_conflict <= w_conflict;
            end
        end else if (w_fire) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky drop flag; a new drop takes priority over a clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_sticky <= 1'b0;
        end else if (w_drop) begin
            r_err_sticky <= 1'b1;
        end else if (err_clr) begin
            r_err_sticky <= 1'b0;
        end
    end

    // Completed output handshakes, wrapping at the counter width.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_xfer_cnt <= '0;
        end else if (w_fire) begin
            r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
        end
    end

    assign out_addr     = r_out_addr;
    assign out_valid    = r_out_valid;
    assign out_conflict = r_out_conflict;
    assign err_sticky   = r_err_sticky;
    assign xfer_cnt     = r_xfer_cnt;

endmodule

// File: tb/tb_bank_addr_xbar_pipe.sv
// Scoreboard bench for bank_addr_xbar_pipe: directed scenarios followed by
// randomized traffic, checked against an arithmetic reference model.
module tb_bank_addr_xbar_pipe;

    localparam int LANES  = 4;
    localparam int ADDR_W = 6;
    localparam int CNT_W  = 4;
    localparam int SEL_W  = 2;
    localparam int AW     = LANES * ADDR_W;
    localparam int SW     = LANES * SEL_W;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   in_addr;
    logic [SW-1:0]   in_sel;
    logic            in_valid;
    logic            in_ready;
    logic            perm_mode;
    logic [AW-1:0]   out_addr;
    logic            out_valid;
    logic            out_ready;
    logic            out_conflict;
    logic            err_sticky;
    logic            err_clr;
    logic [CNT_W-1:0] xfer_cnt;

    bank_addr_xbar_pipe #(.LANES(LANES), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_addr(in_addr), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .perm_mode(perm_mode),
        .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
        .out_conflict(out_conflict), .err_sticky(err_sticky), .err_clr(err_clr),
        .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          conf;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    // Model state describing the DUT after the most recent rising edge.
    logic            armed = 1'b0;
    logic            post_rst = 1'b0;
    logic            m_valid = 1'b0;
    logic            m_err = 1'b0;
    logic [CNT_W-1:0] m_cnt = '0;
    logic            prev_stall = 1'b0;
    logic [AW-1:0]   prev_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sel_of(input logic [SW-1:0] s, input int j);
        return (int'(s) >> (j * SEL_W)) % LANES;
    endfunction

    function automatic logic [AW-1:0] ref_route(input logic [AW-1:0] a, input logic [SW-1:0] s);
        longint r = 0;
        for (int j = 0; j < LANES; j++) begin
            longint v = (longint'(a) >> (sel_of(s, j) * ADDR_W)) % (64'd1 << ADDR_W);
            r += v << (j * ADDR_W);
        end
        return AW'(r);
    endfunction

    function automatic logic ref_conflict(input logic [SW-1:0] s);
        int hits[LANES];
        logic c = 1'b0;
        for (int k = 0; k < LANES; k++) hits[k] = 0;
        for (int j = 0; j < LANES; j++) hits[sel_of(s, j)]++;
        for (int k = 0; k < LANES; k++) if (hits[k] > 1) c = 1'b1;
        return c;
    endfunction

    // Apply one cycle of stimulus; record the expected output if it is accepted.
    task automatic drive(input logic [AW-1:0] a, input logic [SW-1:0] s, input logic v,
                         input logic pm, input logic ordy, input logic eclr);
        exp_t e;
        @(posedge clk);
        #1;
        in_addr = a; in_sel = s; in_valid = v; perm_mode = pm;
        out_ready = ordy; err_clr = eclr;
        @(negedge clk);
        if (rst_n && v && in_ready && !(pm && ref_conflict(s))) begin
            e.addr = ref_route(a, s);
            e.conf = ref_conflict(s);
            q.push_back(e);
        end
    endtask

    task automatic idle(input logic ordy);
        drive($urandom, $urandom, 1'b0, 1'b0, ordy, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0; in_valid = 1'b0; err_clr = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [SW-1:0] rand_sel(input logic perm);
        int p[LANES];
        logic [SW-1:0] s;
        if (!perm) return SW'($urandom);
        for (int k = 0; k < LANES; k++) p[k] = k;
        for (int k = LANES - 1; k > 0; k--) begin
            int r = int'($urandom_range(k, 0));
            int t = p[k];
            p[k] = p[r];
            p[r] = t;
        end
        s = '0;
        for (int k = 0; k < LANES; k++) s = s | (SW'(p[k]) << (k * SEL_W));
        return s;
    endfunction

    // Monitor: compare against the model, pop on handshakes, then predict the next edge.
    always @(negedge clk) begin
        logic acc;
        logic drop;
        exp_t e;
        if (armed) begin
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            check("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
            check("err_sticky", 32'(err_sticky), 32'(m_err));
            if (post_rst) begin
                check("reset_out_addr", 32'(out_addr), 32'd0);
                check("reset_out_conflict", 32'(out_conflict), 32'd0);
            end
            if (prev_stall && out_valid) check("stall_stable", 32'(out_addr), 32'(prev_addr));
            if (rst_n && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("pop_nonempty", 32'd0, 32'd1);
                end else begin
                    e = q.pop_front();
                    check("sb_addr", 32'(out_addr), 32'(e.addr));
                    check("sb_conflict", 32'(out_conflict), 32'(e.conf));
                end
            end
        end
        if (!rst_n) begin
            armed = 1'b1; post_rst = 1'b1;
            m_valid = 1'b0; m_err = 1'b0; m_cnt = '0;
            prev_stall = 1'b0;
            q.delete();
        end else begin
            post_rst = 1'b0;
            acc  = in_valid && (!m_valid || out_ready);
            drop = acc && perm_mode && ref_conflict(in_sel);
            if (m_valid && out_ready) m_cnt = m_cnt + 1'b1;
            if (drop) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            if (acc) m_valid = !drop;
            else if (out_ready) m_valid = 1'b0;
            prev_stall = out_valid && !out_ready;
            prev_addr  = out_addr;
        end
    end

    logic [AW-1:0] base_addr;

    initial begin
        rst_n = 1'b0; in_addr = '0; in_sel = '0; in_valid = 1'b0;
        perm_mode = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        base_addr = {6'h3F, 6'h2A, 6'h15, 6'h01};
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Identity routing.
        drive(base_addr, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        check("identity_addr", 32'(out_addr), 32'h00FEA541);
        check("identity_conflict", 32'(out_conflict), 32'd0);
        idle(1'b1);
        check("identity_cnt", 32'(xfer_cnt), 32'd1);

        // Broadcast of lane 2.
        drive(base_addr, 8'hAA, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        check("bcast_addr", 32'(out_addr), 32'(AW'({4{6'h2A}})));
        check("bcast_conflict", 32'(out_conflict), 32'd1);
        check("bcast_err", 32'(err_sticky), 32'd0);

        // Permutation drops, then a drop coinciding with a clear, then a clear alone.
        drive(base_addr, {2'd0, 2'd0, 2'd1, 2'd2}, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        check("drop_valid", 32'(out_valid), 32'd0);
        check("drop_err", 32'(err_sticky), 32'd1);
        drive(base_addr, {2'd1, 2'd1, 2'd1, 2'd2}, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        check("drop_clr_err", 32'(err_sticky), 32'd1);
        drive(base_addr, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        check("clr_err", 32'(err_sticky), 32'd0);

        // Back-pressure for five cycles with input waiting, then release.
        drive($urandom, rand_sel(1'b1), 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (5) drive($urandom, rand_sel(1'b0), 1'b1, $urandom_range(1, 0), 1'b0, 1'b0);
        drive($urandom, rand_sel(1'b1), 1'b1, 1'b0, 1'b1, 1'b0);
        drive($urandom, rand_sel(1'b1), 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Counter wrap after sixteen handshakes from reset.
        do_reset();
        repeat (16) drive($urandom, rand_sel(1'b0), 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        check("wrap_cnt", 32'(xfer_cnt), 32'd0);

        // Reset while a transfer is held stalled.
        drive($urandom, rand_sel(1'b1), 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        do_reset();
        idle(1'b0);
        check("rst_stall_valid", 32'(out_valid), 32'd0);
        check("rst_stall_ready", 32'(in_ready), 32'd1);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            drive($urandom, rand_sel($urandom_range(1, 0) == 1),
                  $urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1,
                  $urandom_range(3, 0) != 0, $urandom_range(7, 0) == 0);
        end

        repeat (4) idle(1'b1);
        check("sb_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
